// File: rtl/shift_frame_rx.sv
// rtl/shift_frame_rx.sv - recovers start/data/parity/stop framed words from the shift stage serial output
module shift_frame_rx #(
   parameter int DATA_W = 8,
   parameter int PARITY = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              sin,
   input  logic              sh_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              par_err,
   output logic              frm_err,
   output logic              overrun,
   input  logic              ovr_clr,
   output logic              busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_PAR  = 2'd2;
   localparam logic [1:0] ST_STOP = 2'd3;

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic HAS_PAR = (PARITY != 0);
   localparam logic ODD_PAR = (PARITY == 2);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic              rx_par_q, rx_par_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              par_err_q, par_err_d;
   logic              frm_err_q, frm_err_d;
   logic              overrun_q, overrun_d;

   logic stop_hit, good_stop, drain, load, par_calc, par_bad;

   // Frame sequencer: only moves on shift strobes; data assembles LSB-first from the top
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      rx_par_d = rx_par_q;
      if (sh_en) begin
         case (state_q)
            ST_IDLE: begin
               if (!sin) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
               end
            end
            ST_DATA: begin
               sr_d  = {sin, sr_q[DATA_W-1:1]};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = HAS_PAR ? ST_PAR : ST_STOP;
               end
            end
            ST_PAR: begin
               rx_par_d = sin;
               state_d  = ST_STOP;
            end
            default: begin
               // A low stop bit is not reused as a start bit; always return to idle.
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output buffer, error flags and overrun tracking around the stop-bit sample
   always_comb begin
      stop_hit  = sh_en && (state_q == ST_STOP);
      good_stop = stop_hit && sin;
      drain     = dout_valid_q && dout_ready;
      load      = good_stop && (!dout_valid_q || drain);
      par_calc  = (^sr_q) ^ ODD_PAR;
      par_bad   = HAS_PAR && (rx_par_q != par_calc);

      dout_d       = dout_q;
      par_err_d    = par_err_q;
      dout_valid_d = dout_valid_q;
      if (load) begin
         dout_d       = sr_q;
         par_err_d    = par_bad;
         dout_valid_d = 1'b1;
      end else if (drain) begin
         dout_valid_d = 1'b0;
      end

      frm_err_d = stop_hit && !sin;

      // A dropped word outranks a same-edge clear so the loss is never hidden.
      overrun_d = overrun_q;
      if (good_stop && !load) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         rx_par_q     <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         frm_err_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         rx_par_q     <= rx_par_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         par_err_q    <= par_err_d;
         frm_err_q    <= frm_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign par_err    = par_err_q;
   assign frm_err    = frm_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_frame_rx.sv
// tb/tb_shift_frame_rx.sv - vector table, corner sequences and random frames against a word-level model
module tb_shift_frame_rx;

   logic clk, clr;
   logic sin_a, sh_a, rdy_a, oc_a, sel;

   logic sin0, sh0, rdy0, oc0, sin1, sh1, rdy1, oc1;
   logic [7:0] dout0, dout1;
   logic dv0, pe0, fe0, ov0, bz0, dv1, pe1, fe1, ov1, bz1;
   logic [7:0] o_dout;
   logic o_dv, o_pe, o_fe, o_ov, o_bz;

   int total = 0;
   int bad = 0;

   // sel picks which receiver gets the stimulus; the other sees an idle line and no strobes
   assign sin0 = sel ? 1'b1 : sin_a;
   assign sh0  = sel ? 1'b0 : sh_a;
   assign rdy0 = sel ? 1'b0 : rdy_a;
   assign oc0  = sel ? 1'b0 : oc_a;
   assign sin1 = sel ? sin_a : 1'b1;
   assign sh1  = sel ? sh_a : 1'b0;
   assign rdy1 = sel ? rdy_a : 1'b0;
   assign oc1  = sel ? oc_a : 1'b0;

   assign o_dout = sel ? dout1 : dout0;
   assign o_dv   = sel ? dv1 : dv0;
   assign o_pe   = sel ? pe1 : pe0;
   assign o_fe   = sel ? fe1 : fe0;
   assign o_ov   = sel ? ov1 : ov0;
   assign o_bz   = sel ? bz1 : bz0;

   shift_frame_rx #(.DATA_W(8), .PARITY(0)) dut0 (
      .clk(clk), .clr(clr), .sin(sin0), .sh_en(sh0), .dout(dout0), .dout_valid(dv0),
      .dout_ready(rdy0), .par_err(pe0), .frm_err(fe0), .overrun(ov0), .ovr_clr(oc0), .busy(bz0)
   );

   shift_frame_rx #(.DATA_W(8), .PARITY(1)) dut1 (
      .clk(clk), .clr(clr), .sin(sin1), .sh_en(sh1), .dout(dout1), .dout_valid(dv1),
      .dout_ready(rdy1), .par_err(pe1), .frm_err(fe1), .overrun(ov1), .ovr_clr(oc1), .busy(bz1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       sel;
      logic [7:0] w;
      logic       pb;
      logic       stp;
      logic       rs;
      logic       dr;
      logic       oc;
      logic       ev;
      logic [7:0] ed;
      logic       ep;
      logic       ef;
      logic       eo;
      logic       eop;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int gap_of(input int gm);
      if (gm == 0) return 0;
      if (gm == 1) return 1;
      return int'($urandom_range(0, 2));
   endfunction

   task automatic send_bit(input logic b, input int gap);
      repeat (gap) begin
         sh_a = 1'b0;
         tick();
      end
      sin_a = b;
      sh_a  = 1'b1;
      tick();
   endtask

   // drives start, 8 data bits LSB-first, parity (parity receiver only), stop; rdy/ovr_clr only on the stop edge
   task automatic send_frame(input logic [7:0] w, input logic pb, input logic stp,
                             input logic rdy_s, input logic oc_s, input int gm);
      int g;
      rdy_a = 1'b0;
      oc_a  = 1'b0;
      send_bit(1'b0, gap_of(gm));
      for (int i = 0; i < 8; i++) send_bit(w[i], gap_of(gm));
      if (sel) send_bit(pb, gap_of(gm));
      g = gap_of(gm);
      repeat (g) begin
         sh_a = 1'b0;
         tick();
      end
      rdy_a = rdy_s;
      oc_a  = oc_s;
      sin_a = stp;
      sh_a  = 1'b1;
      tick();
      rdy_a = 1'b0;
      oc_a  = 1'b0;
      sin_a = 1'b1;
   endtask

   task automatic post(input logic rdy, input logic oc);
      sin_a = 1'b1;
      sh_a  = 1'b1;
      rdy_a = rdy;
      oc_a  = oc;
      tick();
      rdy_a = 1'b0;
      oc_a  = 1'b0;
   endtask

   initial begin
      logic       mv, mp, mo, good, drain, load, r2, oc2;
      logic [7:0] md, w;
      logic       pb, stp, rs, ocs;

      //          sel   w      pb    stp   rs    dr    oc    ev    ed     ep    ef    eo    eop
      vt[0] = '{1'b0, 8'h9A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3] = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[5] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[8] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};

      clr = 1'b1; sin_a = 1'b1; sh_a = 1'b0; rdy_a = 1'b0; oc_a = 1'b0; sel = 1'b0;
      tick();
      chk("reset_outputs", {o_dout, o_dv, o_pe, o_fe, o_ov, o_bz}, 32'd0);
      clr = 1'b0;
      sh_a = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("idle_c%0d", c), {o_dout, o_dv, o_pe, o_fe, o_ov, o_bz}, 32'd0);
      end

      for (int k = 0; k < 10; k++) begin
         sel = vt[k].sel;
         send_frame(vt[k].w, vt[k].pb, vt[k].stp, vt[k].rs, 1'b0, 0);
         chk($sformatf("vec%0d_valid", k), o_dv, vt[k].ev);
         if (vt[k].ev) begin
            chk($sformatf("vec%0d_dout", k), o_dout, vt[k].ed);
            chk($sformatf("vec%0d_par", k), o_pe, vt[k].ep);
         end
         chk($sformatf("vec%0d_frm", k), o_fe, vt[k].ef);
         chk($sformatf("vec%0d_ovr", k), o_ov, vt[k].eo);
         chk($sformatf("vec%0d_busy", k), o_bz, 1'b0);
         post(vt[k].dr, vt[k].oc);
         chk($sformatf("vec%0d_frm_post", k), o_fe, 1'b0);
         chk($sformatf("vec%0d_valid_post", k), o_dv, vt[k].dr ? 1'b0 : vt[k].ev);
         chk($sformatf("vec%0d_ovr_post", k), o_ov, vt[k].eop);
      end

      // overrun set and ovr_clr on the same edge: set wins; buffer keeps 0x22
      sel = 1'b0;
      send_frame(8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      chk("setwins_ovr", o_ov, 1'b1);
      chk("setwins_dout", o_dout, 8'h22);
      post(1'b0, 1'b1);
      chk("ovrclr_ovr", o_ov, 1'b0);
      post(1'b1, 1'b0);
      chk("setwins_drained", o_dv, 1'b0);

      // strobes every other cycle
      send_frame(8'h9A, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      chk("gapped_valid", o_dv, 1'b1);
      chk("gapped_dout", o_dout, 8'h9A);
      post(1'b1, 1'b0);

      // clear in the middle of a frame
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(i[0], 0);
      chk("mid_busy", o_bz, 1'b1);
      #2 clr = 1'b1;
      #1;
      chk("clr_busy", o_bz, 1'b0);
      chk("clr_valid", o_dv, 1'b0);
      tick();
      clr = 1'b0;
      sin_a = 1'b1;
      tick();
      chk("after_clr_valid", o_dv, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("after_clr_dv", o_dv, 1'b1);
      chk("after_clr_dout", o_dout, 8'hA5);
      post(1'b1, 1'b0);

      // random frames against a word-level model of the buffer and flags
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         mv = 1'b0; mo = 1'b0; md = 8'h00; mp = 1'b0;
         for (int n = 0; n < 30; n++) begin
            w   = 8'($urandom);
            pb  = 1'($urandom);
            stp = ($urandom % 4) != 0;
            rs  = 1'($urandom);
            ocs = ($urandom % 4) == 0;
            send_frame(w, pb, stp, rs, ocs, 2);
            good  = stp;
            drain = mv && rs;
            load  = good && (!mv || drain);
            if (load) begin
               md = w;
               mp = (s == 1) ? (pb != (^w)) : 1'b0;
               mv = 1'b1;
            end else if (drain) begin
               mv = 1'b0;
            end
            if (good && !load) mo = 1'b1;
            else if (ocs) mo = 1'b0;
            chk($sformatf("rnd%0d_%0d_valid", s, n), o_dv, mv);
            if (mv) begin
               chk($sformatf("rnd%0d_%0d_dout", s, n), o_dout, md);
               chk($sformatf("rnd%0d_%0d_par", s, n), o_pe, mp);
            end
            chk($sformatf("rnd%0d_%0d_frm", s, n), o_fe, !stp);
            chk($sformatf("rnd%0d_%0d_ovr", s, n), o_ov, mo);
            chk($sformatf("rnd%0d_%0d_busy", s, n), o_bz, 1'b0);
            r2  = 1'($urandom);
            oc2 = ($urandom % 4) == 0;
            post(r2, oc2);
            if (mv && r2) mv = 1'b0;
            if (oc2) mo = 1'b0;
            chk($sformatf("rnd%0d_%0d_valid_post", s, n), o_dv, mv);
            chk($sformatf("rnd%0d_%0d_frm_post", s, n), o_fe, 1'b0);
            chk($sformatf("rnd%0d_%0d_ovr_post", s, n), o_ov, mo);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
